// File: rtl/strip_alloc_engine.sv
// Strip-packing allocator: requests are placed left-packed into the best-fitting
// horizontal strip of a programmable strip table, scanning one strip per cycle.
module strip_alloc_engine #(
  parameter int ARRAY_W    = 128,
  parameter int ARRAY_H    = 128,
  parameter int NUM_STRIPS = 13,
  parameter int SIZE_W     = 5,
  parameter int COORD_W    = 8,
  parameter int STRIKE_W   = 4,
  parameter int TALL_MIN   = 13
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                cfg_we_i,
  input  logic [3:0]          cfg_idx_i,
  input  logic [SIZE_W-1:0]   cfg_height_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [SIZE_W-1:0]   height_i,
  input  logic [SIZE_W-1:0]   width_i,
  output logic                rsp_valid_o,
  output logic                rsp_fail_o,
  output logic [COORD_W-1:0]  index_x_o,
  output logic [COORD_W-1:0]  index_y_o,
  output logic [STRIKE_W-1:0] strike_o
);

  localparam int AW = COORD_W + 1;
  localparam int YW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SIZE_W-1:0]   r_h   [NUM_STRIPS];
  logic [AW-1:0]       r_occ [NUM_STRIPS];
  logic [SIZE_W-1:0]   r_p;
  logic [SIZE_W-1:0]   r_w;
  logic [3:0]          r_k;
  logic [AW-1:0]       r_y;
  logic                r_found;
  logic                r_best_exact;
  logic [3:0]          r_best_idx;
  logic [AW-1:0]       r_best_occ;
  logic [AW-1:0]       r_best_y;
  logic                r_rsp_valid;
  logic                r_rsp_fail;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_yo;
  logic [STRIKE_W-1:0] r_strike;

  logic          w_accept;
  logic [AW-1:0] w_hk;
  logic [AW-1:0] w_pk;
  logic [AW-1:0] w_occ_k;
  logic          w_tall;
  logic          w_exact;
  logic          w_elig;
  logic          w_better;
  logic [YW-1:0] w_y_sum;
  logic [AW-1:0] w_y_nxt;

  function automatic logic [SIZE_W-1:0] default_height(input logic [4:0] idx);
    case (idx)
      5'd0:    return SIZE_W'(12);
      5'd1:    return SIZE_W'(4);
      5'd2:    return SIZE_W'(11);
      5'd3:    return SIZE_W'(5);
      5'd4:    return SIZE_W'(10);
      5'd5:    return SIZE_W'(6);
      5'd6:    return SIZE_W'(9);
      5'd7:    return SIZE_W'(7);
      5'd8:    return SIZE_W'(8);
      5'd9:    return SIZE_W'(8);
      5'd10:   return SIZE_W'(16);
      5'd11:   return SIZE_W'(16);
      5'd12:   return SIZE_W'(16);
      default: return {SIZE_W{1'b0}};
    endcase
  endfunction

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_fail_o  = r_rsp_fail;
  assign index_x_o   = r_x;
  assign index_y_o   = r_yo;
  assign strike_o    = r_strike;
  assign w_accept    = (r_state == S_IDLE) && req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (r_k == 4'(NUM_STRIPS - 1)) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strip-k evaluation; zero-sized requests are never eligible so they always fail.
  always_comb begin
    w_hk     = AW'(r_h[r_k]);
    w_pk     = AW'(r_p);
    w_occ_k  = r_occ[r_k];
    w_tall   = (w_pk >= AW'(TALL_MIN));
    w_exact  = (w_hk == w_pk) || w_tall;
    w_elig   = (w_hk != {AW{1'b0}}) && (r_p != {SIZE_W{1'b0}}) && (r_w != {SIZE_W{1'b0}})
            && ((w_hk == w_pk) || (w_hk == (w_pk + AW'(1))) || (w_tall && (w_hk >= w_pk)))
            && ((AW'(ARRAY_W) - w_occ_k) >= AW'(r_w))
            && ((YW'(r_y) + YW'(w_pk)) <= YW'(ARRAY_H));
    w_better = w_elig && (!r_found || (w_occ_k < r_best_occ)
            || ((w_occ_k == r_best_occ) && w_exact && !r_best_exact));
    w_y_sum  = YW'(r_y) + YW'(w_hk);
    // Saturate just past the array so the running y can never wrap back into range.
    if (w_y_sum > YW'(ARRAY_H)) begin
      w_y_nxt = AW'(ARRAY_H + 1);
    end else begin
      w_y_nxt = w_y_sum[AW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STRIPS; i++) begin
        r_h[i]   <= default_height(5'(i));
        r_occ[i] <= {AW{1'b0}};
      end
      r_p          <= {SIZE_W{1'b0}};
      r_w          <= {SIZE_W{1'b0}};
      r_k          <= 4'd0;
      r_y          <= {AW{1'b0}};
      r_found      <= 1'b0;
      r_best_exact <= 1'b0;
      r_best_idx   <= 4'd0;
      r_best_occ   <= {AW{1'b0}};
      r_best_y     <= {AW{1'b0}};
      r_rsp_valid  <= 1'b0;
      r_rsp_fail   <= 1'b0;
      r_x          <= {COORD_W{1'b0}};
      r_yo         <= {COORD_W{1'b0}};
      r_strike     <= {STRIKE_W{1'b0}};
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_i) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
              r_occ[i] <= {AW{1'b0}};
            end
            r_strike <= {STRIKE_W{1'b0}};
          end
          if (cfg_we_i && ({1'b0, cfg_idx_i} < 5'(NUM_STRIPS))) begin
            r_h[cfg_idx_i] <= cfg_height_i;
          end
          if (w_accept) begin
            r_p          <= height_i;
            r_w          <= width_i;
            r_k          <= 4'd0;
            r_y          <= {AW{1'b0}};
            r_found      <= 1'b0;
            r_best_exact <= 1'b0;
            r_best_idx   <= 4'd0;
            r_best_occ   <= {AW{1'b0}};
            r_best_y     <= {AW{1'b0}};
          end
        end
        S_SCAN: begin
          r_y <= w_y_nxt;
          r_k <= r_k + 4'd1;
          if (w_better) begin
            r_found      <= 1'b1;
            r_best_exact <= w_exact;
            r_best_idx   <= r_k;
            r_best_occ   <= w_occ_k;
            r_best_y     <= r_y;
          end
        end
        S_COMMIT: begin
          r_rsp_valid <= 1'b1;
          if (r_found) begin
            r_occ[r_best_idx] <= r_best_occ + AW'(r_w);
            r_x               <= r_best_occ[COORD_W-1:0];
            r_yo              <= r_best_y[COORD_W-1:0];
            r_rsp_fail        <= 1'b0;
          end else begin
            r_x        <= COORD_W'(ARRAY_W);
            r_yo       <= COORD_W'(ARRAY_H);
            r_rsp_fail <= 1'b1;
            if (r_strike != {STRIKE_W{1'b1}}) begin
              r_strike <= r_strike + STRIKE_W'(1);
            end
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_alloc_engine.sv
// Directed bench for strip_alloc_engine with hand-computed placements against the
// default strip table (y bases 0,12,16,27,32,42,48,57,64,72,80,96,112).
module tb_strip_alloc_engine;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;
  logic       cfg_we_i;
  logic [3:0] cfg_idx_i;
  logic [4:0] cfg_height_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [4:0] height_i;
  logic [4:0] width_i;
  logic       rsp_valid_o;
  logic       rsp_fail_o;
  logic [7:0] index_x_o;
  logic [7:0] index_y_o;
  logic [3:0] strike_o;

  int checks   = 0;
  int failures = 0;

  strip_alloc_engine dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_height_i (cfg_height_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .height_i     (height_i),
    .width_i      (width_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_fail_o   (rsp_fail_o),
    .index_x_o    (index_x_o),
    .index_y_o    (index_y_o),
    .strike_o     (strike_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [4:0] h, input logic [4:0] w);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    height_i    = h;
    width_i     = w;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Accept a request, wait for its response and check latency, result and hold.
  task automatic do_req(input string tag, input logic [4:0] h, input logic [4:0] w,
                        input logic fail, input logic [7:0] x, input logic [7:0] y);
    int lat;
    lat = 0;
    start_req(h, w);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 14);
    chk({tag, "_fail"}, rsp_fail_o, fail);
    chk({tag, "_x"}, index_x_o, x);
    chk({tag, "_y"}, index_y_o, y);
    chk({tag, "_rdy"}, req_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    chk({tag, "_pulse"}, rsp_valid_o, 1'b0);
    chk({tag, "_hold"}, index_x_o, x);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; clear_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = 4'd0; cfg_height_i = 5'd0;
    req_valid_i = 1'b0; height_i = 5'd0; width_i = 5'd0;
    #23;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_valid", rsp_valid_o, 1'b0);
    chk("rst_x", index_x_o, 8'd0);
    chk("rst_strike", strike_o, 4'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    do_req("a1", 5'd12, 5'd20, 1'b0, 8'd0, 8'd0);
    do_req("a2", 5'd12, 5'd20, 1'b0, 8'd20, 8'd0);
    do_req("a3", 5'd12, 5'd31, 1'b0, 8'd40, 8'd0);
    do_req("a4", 5'd12, 5'd31, 1'b0, 8'd71, 8'd0);
    do_req("full", 5'd12, 5'd31, 1'b1, 8'd128, 8'd128);
    chk("strike1", strike_o, 4'd1);

    do_req("exact4", 5'd4, 5'd10, 1'b0, 8'd0, 8'd12);
    do_req("near3", 5'd3, 5'd10, 1'b0, 8'd10, 8'd12);
    do_req("near9", 5'd9, 5'd7, 1'b0, 8'd0, 8'd48);
    do_req("near7x", 5'd7, 5'd3, 1'b0, 8'd0, 8'd57);
    do_req("tall1", 5'd14, 5'd30, 1'b0, 8'd0, 8'd80);
    do_req("tall2", 5'd14, 5'd30, 1'b0, 8'd0, 8'd96);
    do_req("tall3", 5'd16, 5'd30, 1'b0, 8'd0, 8'd112);
    do_req("tall4", 5'd13, 5'd30, 1'b0, 8'd30, 8'd80);
    do_req("toobig", 5'd20, 5'd1, 1'b1, 8'd128, 8'd128);
    chk("strike2", strike_o, 4'd2);
    do_req("zero_h", 5'd0, 5'd5, 1'b1, 8'd128, 8'd128);
    do_req("zero_w", 5'd12, 5'd0, 1'b1, 8'd128, 8'd128);
    chk("strike4", strike_o, 4'd4);
    for (int i = 0; i < 13; i++) do_req("sat", 5'd20, 5'd1, 1'b1, 8'd128, 8'd128);
    chk("strike_sat", strike_o, 4'd15);

    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    chk("clear_strike", strike_o, 4'd0);
    do_req("after_clr", 5'd12, 5'd20, 1'b0, 8'd0, 8'd0);

    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_idx_i = 4'd0; cfg_height_i = 5'd0;
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
    do_req("cfg_dis", 5'd12, 5'd5, 1'b1, 8'd128, 8'd128);
    chk("cfg_strike", strike_o, 4'd1);

    start_req(5'd12, 5'd5);
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #12;
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o) seen++;
    end
    chk("abort_norsp", seen, 0);
    chk("abort_strike", strike_o, 4'd0);
    do_req("restored", 5'd12, 5'd20, 1'b0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
